rf_decode_wb: RTL and testbench



---
 rtl/rf_decode_wb.sv | 119 +++++++++++
 tb/tb_rf_decode_wb.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_decode_wb.sv
// Register-file decoder with a registered write-back stage.
// Optional pending-stage read bypass: define RF_WB_BYPASS_EN.
module rf_decode_wb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int LINK_REG = 31
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       instruction,
  input  logic [DATA_W-1:0] read_data,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] opcplus4,
  input  logic              jal,
  input  logic              reg_write,
  input  logic              mem_or_io_to_reg,
  input  logic              reg_dst,
  input  logic              flush,
  output logic [DATA_W-1:0] read_data_1,
  output logic [DATA_W-1:0] read_data_2,
  output logic [DATA_W-1:0] imme_extend,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data
);

  localparam int NREG = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LINK_IDX = ADDR_W'(LINK_REG);

  logic [DATA_W-1:0] regs [NREG];

  logic [5:0]        opcode;
  logic [4:0]        rs_f;
  logic [4:0]        rt_f;
  logic [4:0]        rd_f;
  logic [15:0]       imm;
  logic [ADDR_W-1:0] rs_idx;
  logic [ADDR_W-1:0] rt_idx;
  logic [ADDR_W-1:0] rd_idx;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [31:0]       lui_v;
  logic              hit_1;
  logic              hit_2;

  assign opcode = instruction[31:26];
  assign rs_f   = instruction[25:21];
  assign rt_f   = instruction[20:16];
  assign rd_f   = instruction[15:11];
  assign imm    = instruction[15:0];
  assign rs_idx = rs_f[ADDR_W-1:0];
  assign rt_idx = rt_f[ADDR_W-1:0];
  assign rd_idx = rd_f[ADDR_W-1:0];
  assign lui_v  = {imm, 16'h0000};

  // Write address and data select for the incoming request
  always_comb begin
    wr_addr = reg_dst ? rd_idx : rt_idx;
    if (jal)
      wr_addr = LINK_IDX;
    wr_data = mem_or_io_to_reg ? read_data : alu_result;
    if (opcode == 6'b000011 && jal)
      wr_data = opcplus4;
  end

  // Immediate shaping: logical ops zero-extend, lui shifts up
  always_comb begin
    imme_extend = DATA_W'(signed'(imm));
    unique case (1'b1)
      (opcode == 6'h0C),
      (opcode == 6'h0D),
      (opcode == 6'h0E): imme_extend = DATA_W'(imm);
      (opcode == 6'h0F): imme_extend = DATA_W'(lui_v);
      default: ;
    endcase
  end

`ifdef RF_WB_BYPASS_EN
  assign hit_1 = wb_valid && (wb_addr == rs_idx) && (rs_idx != '0);
  assign hit_2 = wb_valid && (wb_addr == rt_idx) && (rt_idx != '0);
`else
  assign hit_1 = 1'b0;
  assign hit_2 = 1'b0;
`endif

  // Combinational reads; r0 is hardwired to zero
  always_comb begin
    read_data_1 = (rs_idx == '0) ? '0 : regs[rs_idx];
    read_data_2 = (rt_idx == '0) ? '0 : regs[rt_idx];
    if (hit_1)
      read_data_1 = wb_data;
    if (hit_2)
      read_data_2 = wb_data;
  end

  // Capture the request into the write-back stage
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
    end else begin
      wb_valid <= reg_write && !flush && (wr_addr != '0);
      wb_addr  <= wr_addr;
      wb_data  <= wr_data;
    end
  end

  // Commit the pending write into the array
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
    end else if (wb_valid && (wb_addr != '0)) begin
      regs[wb_addr] <= wb_data;
    end
  end

endmodule

// File: tb/tb_rf_decode_wb.sv
// Directed self-checking bench for rf_decode_wb.
// Expectations follow the RF_WB_BYPASS_EN build setting.
module tb_rf_decode_wb;

`ifdef RF_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic [31:0] read_data;
  logic [31:0] alu_result;
  logic [31:0] opcplus4;
  logic        jal;
  logic        reg_write;
  logic        mem_or_io_to_reg;
  logic        reg_dst;
  logic        flush;
  logic [31:0] read_data_1;
  logic [31:0] read_data_2;
  logic [31:0] imme_extend;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  int checks = 0;
  int errors = 0;

  rf_decode_wb dut (
    .clock            (clock),
    .reset            (reset),
    .instruction      (instruction),
    .read_data        (read_data),
    .alu_result       (alu_result),
    .opcplus4         (opcplus4),
    .jal              (jal),
    .reg_write        (reg_write),
    .mem_or_io_to_reg (mem_or_io_to_reg),
    .reg_dst          (reg_dst),
    .flush            (flush),
    .read_data_1      (read_data_1),
    .read_data_2      (read_data_2),
    .imme_extend      (imme_extend),
    .wb_valid         (wb_valid),
    .wb_addr          (wb_addr),
    .wb_data          (wb_data)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(
    input logic [5:0]  op,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [15:0] im
  );
    return {op, rs, rt, im};
  endfunction

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    reg_write        = 1'b0;
    flush            = 1'b0;
    jal              = 1'b0;
    mem_or_io_to_reg = 1'b0;
  endtask

  task automatic wr(input logic [4:0] rd, input logic [31:0] v);
    reg_write        = 1'b1;
    reg_dst          = 1'b1;
    jal              = 1'b0;
    flush            = 1'b0;
    mem_or_io_to_reg = 1'b0;
    alu_result       = v;
    instruction      = mk(6'h00, 5'd0, 5'd0, {rd, 11'd0});
  endtask

  logic [5:0]  iop [6];
  logic [15:0] iim [6];
  logic [31:0] iex [6];

  initial begin
    iop[0] = 6'h08; iim[0] = 16'h8001; iex[0] = 32'hFFFF_8001;
    iop[1] = 6'h0D; iim[1] = 16'h8001; iex[1] = 32'h0000_8001;
    iop[2] = 6'h0F; iim[2] = 16'h8001; iex[2] = 32'h8001_0000;
    iop[3] = 6'h0C; iim[3] = 16'hF00F; iex[3] = 32'h0000_F00F;
    iop[4] = 6'h0E; iim[4] = 16'hFFFF; iex[4] = 32'h0000_FFFF;
    iop[5] = 6'h23; iim[5] = 16'h7FFF; iex[5] = 32'h0000_7FFF;

    reset = 1'b1;
    instruction = '0;
    read_data = '0;
    alu_result = '0;
    opcplus4 = '0;
    reg_dst = 1'b0;
    idle();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    chk("rst_valid", 32'(wb_valid), 32'd0);
    chk("rst_addr", 32'(wb_addr), 32'd0);
    chk("rst_data", wb_data, 32'd0);

    // reset while a write sits in the stage
    reg_write = 1'b1;
    reg_dst = 1'b0;
    instruction = mk(6'h00, 5'd0, 5'd5, 16'h0);
    alu_result = 32'h0000_DEAD;
    cyc();
    chk("mid_valid", 32'(wb_valid), 32'd1);
    chk("mid_addr", 32'(wb_addr), 32'd5);
    idle();
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(wb_valid), 32'd0);
    cyc();
    reset = 1'b0;
    instruction = mk(6'h00, 5'd5, 5'd5, 16'h0);
    #1;
    chk("mid_r5_a", read_data_1, 32'd0);
    cyc();
    chk("mid_r5_b", read_data_2, 32'd0);

    // R-type write to r8
    wr(5'd8, 32'h0000_1234);
    cyc();
    idle();
    instruction = mk(6'h00, 5'd8, 5'd0, 16'h0);
    #1;
    chk("rt_wb_addr", 32'(wb_addr), 32'd8);
    chk("rt_wb_data", wb_data, 32'h1234);
    chk("rt_n1", read_data_1, BYP ? 32'h1234 : 32'h0);
    cyc();
    chk("rt_n2", read_data_1, 32'h1234);

    // JAL links to r31
    reg_write = 1'b1;
    reg_dst = 1'b0;
    jal = 1'b1;
    instruction = mk(6'h03, 5'd0, 5'd0, 16'h0);
    opcplus4 = 32'h0040_0008;
    alu_result = 32'h5555_5555;
    cyc();
    chk("jal_valid", 32'(wb_valid), 32'd1);
    chk("jal_addr", 32'(wb_addr), 32'd31);
    chk("jal_data", wb_data, 32'h0040_0008);
    idle();
    instruction = mk(6'h00, 5'd0, 5'd31, 16'h0);
    #1;
    chk("jal_n1", read_data_2, BYP ? 32'h0040_0008 : 32'h0);
    cyc();
    chk("jal_n2", read_data_2, 32'h0040_0008);

    // write to r0 is dropped
    reg_write = 1'b1;
    reg_dst = 1'b0;
    mem_or_io_to_reg = 1'b1;
    read_data = 32'hFFFF_FFFF;
    instruction = mk(6'h00, 5'd0, 5'd0, 16'h0);
    cyc();
    chk("r0_valid", 32'(wb_valid), 32'd0);
    chk("r0_wb_data", wb_data, 32'hFFFF_FFFF);
    idle();
    cyc();
    chk("r0_rd1", read_data_1, 32'd0);
    chk("r0_rd2", read_data_2, 32'd0);

    // flush cancels the incoming write
    wr(5'd3, 32'h33);
    cyc();
    idle();
    cyc();
    instruction = mk(6'h00, 5'd3, 5'd0, 16'h0);
    #1;
    chk("fl_r3_init", read_data_1, 32'h33);
    wr(5'd3, 32'h99);
    flush = 1'b1;
    cyc();
    chk("fl_valid", 32'(wb_valid), 32'd0);
    idle();
    cyc();
    instruction = mk(6'h00, 5'd3, 5'd0, 16'h0);
    #1;
    chk("fl_r3", read_data_1, 32'h33);

    // flush leaves an already-staged write alone
    wr(5'd6, 32'h66);
    cyc();
    wr(5'd7, 32'h77);
    flush = 1'b1;
    cyc();
    idle();
    instruction = mk(6'h00, 5'd6, 5'd7, 16'h0);
    #1;
    chk("fl_r6", read_data_1, 32'h66);
    chk("fl_r7", read_data_2, 32'h0);

    // back-to-back writes to r4
    wr(5'd4, 32'd1);
    cyc();
    wr(5'd4, 32'd2);
    instruction[25:21] = 5'd4;
    #1;
    chk("b2b_n1", read_data_1, BYP ? 32'd1 : 32'd0);
    cyc();
    idle();
    instruction = mk(6'h00, 5'd4, 5'd4, 16'h0);
    #1;
    chk("b2b_n2", read_data_1, BYP ? 32'd2 : 32'd1);
    cyc();
    chk("b2b_n3", read_data_2, 32'd2);

    // immediate shaping
    for (int i = 0; i < 6; i++) begin
      instruction = mk(iop[i], 5'd0, 5'd0, iim[i]);
      #1;
      chk($sformatf("imm_%0d", i), imme_extend, iex[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
